register_writeback: RTL and testbench
=====================================

Name: register_writeback

Overview:
- Writer side of the integer register file: arbitrates ALU results and buffered load responses onto the single register-file write port.
- Keeps a pending-load scoreboard so decode can detect read-after-load hazards.
- Sits between the execute/memory stages and the register file write port; decode queries busy bits alongside its two register reads.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 5, register index width (NUM_REGS = 2**ADDR_WIDTH)
FIFO_DEPTH, 4, load-response buffer entries (power of two, >= 2)

Ports:
i_Clock  in  1  clock
i_Reset  in  1  synchronous, active-high reset
i_AluValid  in  1  ALU result valid; always accepted, no backpressure
i_AluAddr  in  ADDR_WIDTH  ALU destination register
i_AluData  in  DATA_WIDTH  ALU result
i_LdIssue  in  1  load issued this cycle; marks destination busy
i_LdIssueAddr  in  ADDR_WIDTH  load destination register
i_LdRespValid  in  1  load response valid
i_LdRespAddr  in  ADDR_WIDTH  load response destination
i_LdRespData  in  DATA_WIDTH  load data
o_LdRespReady  out  1  FIFO can accept a response
o_WrAddr  out  ADDR_WIDTH  register file write address
o_WrData  out  DATA_WIDTH  register file write data
o_WrEnable  out  1  register file write enable
i_QryAddrA  in  ADDR_WIDTH  hazard query A
i_QryAddrB  in  ADDR_WIDTH  hazard query B
o_BusyA  out  1  query A register has a load outstanding
o_BusyB  out  1  query B register has a load outstanding
o_Pending  out  1  any load outstanding
o_FifoLevel  out  $clog2(FIFO_DEPTH+1)  buffered responses

Behaviour:
- Clocking: one clock, i_Clock. Reset i_Reset is synchronous and active-high.
- Reset: FIFO emptied; scoreboard cleared; o_WrEnable=0, o_WrAddr=0, o_WrData=0. While in reset, all inputs are ignored and o_LdRespReady=0. A reset mid-operation drops all buffered responses and pending marks.
- FIFO:
  - A response transfers when i_LdRespValid & o_LdRespReady.
  - o_LdRespReady = ~full & ~i_Reset. It depends only on the current level, not on a same-cycle pop.
  - Push and pop in the same cycle keep the level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Arbitration, each cycle:
  - If i_AluValid, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the head is popped and selected.
  - Otherwise nothing is selected.
  - ALU has strict priority; loads wait while ALU is valid every cycle.
- Write port: registered, with one cycle latency from selection.
  - o_WrEnable = selection made & (selected addr != 0).
  - o_WrAddr/o_WrData update on every selection, including addr 0. They hold their value when nothing is selected.
- Latency:
  - ALU valid at cycle N gives a write at N+1.
  - A response accepted at N is in the FIFO at N+1 and produces a write at N+2 at the earliest.
- Scoreboard, one bit per register 1..NUM_REGS-1 (register 0 never busy):
  - Set: i_LdIssue & (i_LdIssueAddr != 0).
  - Clear: the register of a popped FIFO entry, in the pop cycle. Cleared bits are visible next cycle, together with o_WrEnable.
  - Set and clear of the same register in the same cycle: set wins.
  - An ALU write to a busy register writes the data and leaves the bit unchanged.
- o_BusyA/B are combinational lookups of the current scoreboard. A query address of 0 gives 0.
- o_Pending = OR of all scoreboard bits.
- A load response to register 0 is accepted and popped, with no write and no scoreboard change.

Optional Feature:
WB_FORWARD_EN
- With the macro defined:
  - Adds outputs o_FwdHitA, o_FwdHitB (1 bit) and o_FwdDataA, o_FwdDataB (DATA_WIDTH).
  - o_FwdHitX = o_WrEnable & (o_WrAddr == i_QryAddrX) & (i_QryAddrX != 0).
  - o_FwdDataX = o_WrData.
  - This covers the register file's same-cycle read of old data.
- Without the macro: the ports do not exist and no compare logic is built.

Test Plan:
- ALU-only: i_AluValid=1, addr=5, data=0xDEADBEEF at cycle N -> o_WrEnable=1, o_WrAddr=5, o_WrData=0xDEADBEEF at N+1, else idle 0.
- Load round trip: issue addr=7 -> o_BusyA=1 (qry 7) and o_Pending=1 next cycle; response 7/0x1234 accepted at N, no ALU -> write 7/0x1234 at N+2; o_BusyA=0 and o_Pending=0 at N+2.
- Priority and full: hold i_AluValid=1 for 8 cycles while pushing 5 responses with FIFO_DEPTH=4 -> o_LdRespReady=0 after 4 accepts, o_FifoLevel=4. After ALU drops, 4 load writes in order on 4 consecutive cycles.
- Register 0: ALU write to x0 and response to x0 -> o_WrEnable stays 0; response consumed (level returns to 0); o_BusyA=0 for query 0 after issuing a load to x0.
- Set/clear collision: entry for x3 popped in the same cycle i_LdIssue addr=3 -> o_BusyA (qry 3) remains 1.
- Reset mid-flight: 3 entries buffered and 2 pending, i_Reset=1 for one cycle -> o_FifoLevel=0, o_Pending=0, o_WrEnable=0, no stale writes afterwards. With WB_FORWARD_EN, during a write of x9, query A=9 -> o_FwdHitA=1 and o_FwdDataA equals o_WrData.

Source files
------------

// File: rtl/register_writeback_if.sv
// rtl/register_writeback_if.sv - writeback port bundle: ALU/load inputs, register-file write, hazard queries
// Optional macro WB_FORWARD_EN adds the write-port forwarding outputs.
interface register_writeback_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic                  i_AluValid;
  logic [ADDR_WIDTH-1:0] i_AluAddr;
  logic [DATA_WIDTH-1:0] i_AluData;
  logic                  i_LdIssue;
  logic [ADDR_WIDTH-1:0] i_LdIssueAddr;
  logic                  i_LdRespValid;
  logic [ADDR_WIDTH-1:0] i_LdRespAddr;
  logic [DATA_WIDTH-1:0] i_LdRespData;
  logic                  o_LdRespReady;
  logic [ADDR_WIDTH-1:0] o_WrAddr;
  logic [DATA_WIDTH-1:0] o_WrData;
  logic                  o_WrEnable;
  logic [ADDR_WIDTH-1:0] i_QryAddrA;
  logic [ADDR_WIDTH-1:0] i_QryAddrB;
  logic                  o_BusyA;
  logic                  o_BusyB;
  logic                  o_Pending;
  logic [LVL_W-1:0]      o_FifoLevel;
`ifdef WB_FORWARD_EN
  logic                  o_FwdHitA;
  logic                  o_FwdHitB;
  logic [DATA_WIDTH-1:0] o_FwdDataA;
  logic [DATA_WIDTH-1:0] o_FwdDataB;
`endif

  modport master (
    output i_AluValid, i_AluAddr, i_AluData, i_LdIssue, i_LdIssueAddr,
    output i_LdRespValid, i_LdRespAddr, i_LdRespData, i_QryAddrA, i_QryAddrB,
    input  o_LdRespReady, o_WrAddr, o_WrData, o_WrEnable,
    input  o_BusyA, o_BusyB, o_Pending, o_FifoLevel
`ifdef WB_FORWARD_EN
    , input o_FwdHitA, o_FwdHitB, o_FwdDataA, o_FwdDataB
`endif
  );

  modport slave (
    input  i_AluValid, i_AluAddr, i_AluData, i_LdIssue, i_LdIssueAddr,
    input  i_LdRespValid, i_LdRespAddr, i_LdRespData, i_QryAddrA, i_QryAddrB,
    output o_LdRespReady, o_WrAddr, o_WrData, o_WrEnable,
    output o_BusyA, o_BusyB, o_Pending, o_FifoLevel
`ifdef WB_FORWARD_EN
    , output o_FwdHitA, o_FwdHitB, o_FwdDataA, o_FwdDataB
`endif
  );
endinterface

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - arbitrates ALU results and buffered load data onto the register-file write port
// Optional macro WB_FORWARD_EN adds forwarding of the in-flight write to the hazard queries.
module register_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 i_Clock,
  input logic                 i_Reset,
  register_writeback_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);
  // Ready looks only at the stored level so it never depends on this cycle's pop.
  assign bus.o_LdRespReady = ~full & ~i_Reset;
  assign push = bus.i_LdRespValid & bus.o_LdRespReady;
  assign pop  = ~bus.i_AluValid & ~empty;

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (bus.i_AluValid) begin
      sel_valid = 1'b1;
      sel_addr  = bus.i_AluAddr;
      sel_data  = bus.i_AluData;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_addr  = fifo_addr[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end
  end

  // Issue is applied after the pop clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (pop) begin
      busy_next[fifo_addr[rd_ptr]] = 1'b0;
    end
    if (bus.i_LdIssue) begin
      busy_next[bus.i_LdIssueAddr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.i_LdRespAddr;
      fifo_data[wr_ptr] <= bus.i_LdRespData;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      busy      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      busy    <= busy_next;
      wr_en_q <= sel_valid & (sel_addr != '0);
      if (sel_valid) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  assign bus.o_WrEnable  = wr_en_q;
  assign bus.o_WrAddr    = wr_addr_q;
  assign bus.o_WrData    = wr_data_q;
  assign bus.o_BusyA     = busy[bus.i_QryAddrA];
  assign bus.o_BusyB     = busy[bus.i_QryAddrB];
  assign bus.o_Pending   = |busy;
  assign bus.o_FifoLevel = level;

`ifdef WB_FORWARD_EN
  assign bus.o_FwdHitA  = wr_en_q & (wr_addr_q == bus.i_QryAddrA) & (bus.i_QryAddrA != '0);
  assign bus.o_FwdHitB  = wr_en_q & (wr_addr_q == bus.i_QryAddrB) & (bus.i_QryAddrB != '0);
  assign bus.o_FwdDataA = wr_data_q;
  assign bus.o_FwdDataB = wr_data_q;
`endif
endmodule

// File: tb/tb_register_writeback.sv
// tb/tb_register_writeback.sv - self-checking bench for register_writeback (vectors, corner sequences, random vs model)
module tb_register_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus ();
  register_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
    logic iv; logic [AW-1:0] ia;
    logic rv; logic [AW-1:0] ra; logic [DW-1:0] rd;
    logic [AW-1:0] qa;
    logic e_en; logic [AW-1:0] e_addr; logic [DW-1:0] e_data;
    logic e_busy; logic e_pend; int e_lvl;
  } vec_t;

  ent_t          mq[$];
  bit            mbusy[32];
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            n_chk = 0;
  int            n_fail = 0;
  vec_t          vecs[9];
  int            acc_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_busy(input logic [AW-1:0] q);
    return (q != 0) && mbusy[q];
  endfunction

  function automatic bit m_pending();
    bit p = 0;
    foreach (mbusy[i]) p |= mbusy[i];
    return p;
  endfunction

  function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic iv, input logic [AW-1:0] ia,
                              input logic rv, input logic [AW-1:0] ra, input logic [DW-1:0] rd,
                              input logic [AW-1:0] qa, input logic e_en, input logic [AW-1:0] e_addr,
                              input logic [DW-1:0] e_data, input logic e_busy, input logic e_pend,
                              input int e_lvl);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.iv = iv; v.ia = ia;
    v.rv = rv; v.ra = ra; v.rd = rd; v.qa = qa;
    v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_busy = e_busy; v.e_pend = e_pend; v.e_lvl = e_lvl;
    return v;
  endfunction

  // One clock: drive inputs, check combinational outputs, advance the model, check registered outputs.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic iv, input logic [AW-1:0] ia,
                      input logic rv, input logic [AW-1:0] ra, input logic [DW-1:0] rd,
                      input logic r, input logic [AW-1:0] qa, input logic [AW-1:0] qb);
    ent_t e;
    bit   acc;
    bus.i_AluValid = av; bus.i_AluAddr = aa; bus.i_AluData = ad;
    bus.i_LdIssue = iv; bus.i_LdIssueAddr = ia;
    bus.i_LdRespValid = rv; bus.i_LdRespAddr = ra; bus.i_LdRespData = rd;
    bus.i_QryAddrA = qa; bus.i_QryAddrB = qb;
    rst = r;
    #1;
    chk("ready_pre", bus.o_LdRespReady, (!r && mq.size() < FD));
    chk("busy_a_pre", bus.o_BusyA, m_busy(qa));
    chk("busy_b_pre", bus.o_BusyB, m_busy(qb));
    chk("level_pre", bus.o_FifoLevel, mq.size());
    acc = !r && rv && (mq.size() < FD);
    if (r) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
      m_en = 0; m_addr = 0; m_data = 0;
    end else begin
      if (av) begin
        m_en = (aa != 0); m_addr = aa; m_data = ad;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        mbusy[e.a] = 0;
        m_en = (e.a != 0); m_addr = e.a; m_data = e.d;
      end else begin
        m_en = 0;
      end
      if (iv && ia != 0) mbusy[ia] = 1;
      if (acc) mq.push_back(ent_t'{a: ra, d: rd});
    end
    @(posedge clk);
    #1;
    chk("wr_en", bus.o_WrEnable, m_en);
    chk("wr_addr", bus.o_WrAddr, m_addr);
    chk("wr_data", bus.o_WrData, m_data);
    chk("level", bus.o_FifoLevel, mq.size());
    chk("pending", bus.o_Pending, m_pending());
    chk("busy_a", bus.o_BusyA, m_busy(qa));
    chk("busy_b", bus.o_BusyB, m_busy(qb));
  endtask

  task automatic idle(input logic [AW-1:0] qa);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, qa, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    vecs[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 7, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    vecs[1] = mk(0, 0, 0,            0, 0, 0, 0, 0, 7, 0, 5, 32'hDEADBEEF, 0, 0, 0);
    vecs[2] = mk(0, 0, 0,            1, 7, 0, 0, 0, 7, 0, 5, 32'hDEADBEEF, 1, 1, 0);
    vecs[3] = mk(0, 0, 0,            0, 0, 1, 7, 32'h1234, 7, 0, 5, 32'hDEADBEEF, 1, 1, 1);
    vecs[4] = mk(0, 0, 0,            0, 0, 0, 0, 0, 7, 1, 7, 32'h1234, 0, 0, 0);
    vecs[5] = mk(1, 0, 32'h55,       0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0);
    vecs[6] = mk(0, 0, 0,            0, 0, 1, 0, 32'h66, 0, 0, 0, 32'h55, 0, 0, 1);
    vecs[7] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 32'h66, 0, 0, 0);
    vecs[8] = mk(0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0, 32'h66, 0, 0, 0);

    bus.i_AluValid = 0; bus.i_AluAddr = 0; bus.i_AluData = 0;
    bus.i_LdIssue = 0; bus.i_LdIssueAddr = 0;
    bus.i_LdRespValid = 1; bus.i_LdRespAddr = 3; bus.i_LdRespData = 0;
    bus.i_QryAddrA = 0; bus.i_QryAddrB = 0;
    rst = 1;
    m_en = 0; m_addr = 0; m_data = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_ready", bus.o_LdRespReady, 0);
    chk("reset_wr_en", bus.o_WrEnable, 0);
    chk("reset_wr_addr", bus.o_WrAddr, 0);
    chk("reset_wr_data", bus.o_WrData, 0);
    chk("reset_level", bus.o_FifoLevel, 0);
    chk("reset_pending", bus.o_Pending, 0);

    // Directed vectors: ALU-only, load round trip, register 0 handling
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].iv, vecs[i].ia,
           vecs[i].rv, vecs[i].ra, vecs[i].rd, 0, vecs[i].qa, 0);
      chk($sformatf("vec%0d_en", i), bus.o_WrEnable, vecs[i].e_en);
      chk($sformatf("vec%0d_addr", i), bus.o_WrAddr, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), bus.o_WrData, vecs[i].e_data);
      chk($sformatf("vec%0d_busy", i), bus.o_BusyA, vecs[i].e_busy);
      chk($sformatf("vec%0d_pend", i), bus.o_Pending, vecs[i].e_pend);
      chk($sformatf("vec%0d_lvl", i), bus.o_FifoLevel, vecs[i].e_lvl);
    end

    // ALU priority while the load buffer fills up
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, AW'(10 + i), DW'(i), 0, 0, 1, AW'(20 + acc_cnt), DW'(100 + acc_cnt), 0, 0, 0);
      if (acc_cnt < FD) acc_cnt++;
    end
    chk("full_level", bus.o_FifoLevel, 4);
    chk("full_ready", bus.o_LdRespReady, 0);
    for (int j = 0; j < 4; j++) begin
      idle(0);
      chk($sformatf("drain%0d_en", j), bus.o_WrEnable, 1);
      chk($sformatf("drain%0d_addr", j), bus.o_WrAddr, 20 + j);
      chk($sformatf("drain%0d_data", j), bus.o_WrData, 100 + j);
    end
    chk("drain_level", bus.o_FifoLevel, 0);

    // Clear and reissue of the same register in one cycle
    do_reset();
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 1, 3, 32'h77, 0, 3, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, 3, 0);
    chk("collide_busy", bus.o_BusyA, 1);
    chk("collide_wr_addr", bus.o_WrAddr, 3);
    chk("collide_wr_en", bus.o_WrEnable, 1);
    idle(3);
    chk("collide_busy_hold", bus.o_BusyA, 1);

    // Reset with responses buffered and loads pending
    do_reset();
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 4, 6);
    step(0, 0, 0, 1, 6, 0, 0, 0, 0, 4, 6);
    step(1, 1, 32'hA, 0, 0, 1, 4, 32'hB, 0, 4, 6);
    step(1, 1, 32'hA, 0, 0, 1, 6, 32'hC, 0, 4, 6);
    step(1, 1, 32'hA, 0, 0, 1, 9, 32'hD, 0, 4, 6);
    chk("mid_level", bus.o_FifoLevel, 3);
    chk("mid_pending", bus.o_Pending, 1);
    do_reset();
    chk("rst_level", bus.o_FifoLevel, 0);
    chk("rst_pending", bus.o_Pending, 0);
    chk("rst_wr_en", bus.o_WrEnable, 0);
    for (int j = 0; j < 3; j++) begin
      idle(4);
      chk($sformatf("post_rst%0d_en", j), bus.o_WrEnable, 0);
    end

`ifdef WB_FORWARD_EN
    step(1, 9, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 9, 9);
    chk("fwd_hit_a", bus.o_FwdHitA, 1);
    chk("fwd_data_a", bus.o_FwdDataA, 32'hCAFEF00D);
    chk("fwd_hit_b", bus.o_FwdHitB, 1);
    bus.i_QryAddrA = 0;
    #1;
    chk("fwd_hit_a_zero", bus.o_FwdHitA, 0);
    idle(9);
    chk("fwd_hit_a_idle", bus.o_FwdHitA, 0);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), DW'($urandom),
           $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), DW'($urandom),
           $urandom_range(0, 49) == 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
